// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Execute-stage partner of the fetch-side branch predictor. Each fetched
//   instruction's prediction travels through two metadata registers
//   (IF/ID, ID/EX). In EX the prediction is checked against the real
//   outcome, a same-cycle front-end redirect is raised on a mispredict, and
//   a registered predictor-update transaction follows one cycle later for
//   every resolved branch or jump.
//
// Parameters
//   RESET_PC        PC value loaded into the metadata/update PC fields on clear
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   if_*            IF-stage instruction and its prediction (taken/target/hit)
//   stall_id        hold IF/ID (ID/EX takes a bubble unless stall_ex)
//   stall_ex        hold ID/EX and suppress resolution
//   flush_ext       external trap/exception flush of both stages
//   ex_is_branch    EX holds a conditional branch
//   ex_is_jump      EX holds a direct jump (always taken)
//   ex_taken        actual branch direction
//   ex_target       actual computed target
//   redirect_*      combinational redirect request and correct next PC
//   update_*        registered predictor-update transaction
//
// Optional build macro
//   BRU_PERF_CNT_EN adds saturating counters perf_branches / perf_mispredicts

module branch_resolve_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic        if_pred_taken,
  input  logic [31:0] if_pred_target,
  input  logic        if_pred_hit,
  input  logic        stall_id,
  input  logic        stall_ex,
  input  logic        flush_ext,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        update_en,
  output logic [31:0] update_pc,
  output logic        update_taken,
  output logic [31:0] update_target
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
`endif
);

  // IF/ID metadata
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_pt;
  logic [31:0] id_pred_target;

  // ID/EX metadata
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_pt;
  logic [31:0] ex_pred_target;

  // Resolution
  logic        if_pt;
  logic        act_taken;
  logic        resolve;
  logic        dir_miss;
  logic        tgt_miss;
  logic        mispredict;
  logic        kill;

  // A BHT "taken" without a BTB hit fetched the fall-through path, so it is
  // effectively a not-taken prediction.
  assign if_pt = if_pred_taken & if_pred_hit;

  // Both metadata stages are discarded on reset, external flush, or our own
  // redirect (the younger instructions were fetched down the wrong path).
  assign kill = rst | flush_ext | redirect_valid;

  always_ff @(posedge clk) begin
    if (kill) begin
      id_valid       <= 1'b0;
      id_pc          <= RESET_PC;
      id_pt          <= 1'b0;
      id_pred_target <= '0;
    end else if (!stall_id) begin
      id_valid       <= if_valid;
      id_pc          <= if_pc;
      id_pt          <= if_pt;
      id_pred_target <= if_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      ex_valid       <= 1'b0;
      ex_pc          <= RESET_PC;
      ex_pt          <= 1'b0;
      ex_pred_target <= '0;
    end else if (stall_ex) begin
      ex_valid       <= ex_valid;
    end else if (stall_id) begin
      // ID is held, so EX receives a bubble; the other fields are don't-care.
      ex_valid       <= 1'b0;
    end else begin
      ex_valid       <= id_valid;
      ex_pc          <= id_pc;
      ex_pt          <= id_pt;
      ex_pred_target <= id_pred_target;
    end
  end

  always_comb begin
    act_taken      = ex_is_jump | ex_taken;
    resolve        = ex_valid & (ex_is_branch | ex_is_jump) & ~stall_ex & ~flush_ext;
    dir_miss       = act_taken != ex_pt;
    // A correct taken direction still mispredicts if the BTB target is stale.
    tgt_miss       = act_taken & ex_pt & (ex_target != ex_pred_target);
    mispredict     = resolve & (dir_miss | tgt_miss);
    redirect_valid = mispredict;
    redirect_pc    = act_taken ? ex_target : ex_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      update_en     <= 1'b0;
      update_pc     <= RESET_PC;
      update_taken  <= 1'b0;
      update_target <= '0;
    end else begin
      update_en <= resolve;
      if (resolve) begin
        update_pc     <= ex_pc;
        update_taken  <= act_taken;
        update_target <= ex_target;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (resolve && (perf_branches != '1)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if (mispredict && (perf_mispredicts != '1)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`endif

endmodule
